// File: rtl/gate_tester.sv
// gate_tester: steps a two-input gate through all four {a,b} vectors, waits
// SETTLE cycles per vector, samples y once and compares it with TT. It reports
// pass/fail, a mismatch count and a per-vector failure mask.
//
// Request handshake: start is a single-cycle request. It is accepted on a
// rising clk edge only while the FSM is in IDLE. busy rises on that same edge.
// Requests seen while busy or in the DONE cycle are dropped, not queued.
// done is a one-cycle pulse that marks the point where pass, err_cnt and
// fail_mask are final. Those results hold until the next accepted start or
// until rst is asserted.
//
// SETTLE must lie in 1..15 because the settle counter is 4 bits wide.
module gate_tester #(
  parameter logic [3:0] TT     = 4'b0111,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // DRIVE ends when the counter reaches this value.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, state_next;
  logic [1:0] idx, idx_next;
  logic [3:0] settle_cnt, settle_next;
  logic [2:0] err_next;
  logic [3:0] mask_next;
  logic       pass_next;
  logic       mismatch;
  logic       a_next, b_next, busy_next, done_next;

  // The gate output only matters during SAMPLE. It is compared with the
  // expected truth-table bit for the current vector.
  assign mismatch = (y != TT[idx]);

  // Next-state logic and result bookkeeping.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    settle_next = settle_cnt;
    err_next    = err_cnt;
    mask_next   = fail_mask;
    pass_next   = pass;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next  = DRIVE;
          idx_next    = 2'd0;
          settle_next = 4'd0;
          err_next    = 3'd0;
          mask_next   = 4'd0;
          pass_next   = 1'b0;
        end
      end
      DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next  = SAMPLE;
          settle_next = 4'd0;
        end else begin
          settle_next = settle_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_next       = err_cnt + 3'd1;
          mask_next[idx] = 1'b1;
        end
        if (idx == 2'd3) begin
          state_next = DONE;
          // The final vector's result is folded in here so that pass is
          // correct on the edge that enters DONE.
          pass_next  = (err_cnt == 3'd0) && !mismatch;
        end else begin
          state_next = DRIVE;
          idx_next   = idx + 2'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output values are derived from the next state so that every output can
  // come straight from a flop and still line up with the state it belongs to.
  always_comb begin
    busy_next = (state_next == DRIVE) || (state_next == SAMPLE);
    done_next = (state_next == DONE);
    a_next    = busy_next ? idx_next[1] : 1'b0;
    b_next    = busy_next ? idx_next[0] : 1'b0;
  end

  // State register, vector index and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      settle_cnt <= settle_next;
    end
  end

  // Registered outputs. None of them has a combinational path from y or start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      a         <= a_next;
      b         <= b_next;
      busy      <= busy_next;
      done      <= done_next;
      pass      <= pass_next;
      err_cnt   <= err_next;
      fail_mask <= mask_next;
    end
  end

  assign state_dbg = state;

endmodule
